// File: rtl/inst_sequencer_if.sv
// Decoder-facing bus of the 6502 instruction sequencer: strobes, pins and bus
// byte in, instruction register, cycle and pending flags out.
interface inst_sequencer_if;
    logic [7:0] din;
    logic       irq_n;
    logic       nmi_n;
    logic       irqdis;
    logic       icyc;
    logic       rcyc;
    logic       scyc;
    logic       sinst;
    logic [7:0] inst;
    logic [2:0] cycle;
    logic       clr;
    logic       nmi;
    logic       irq;
    logic       seqerr;

    modport master (
        output din, irq_n, nmi_n, irqdis, icyc, rcyc, scyc, sinst,
        input  inst, cycle, clr, nmi, irq, seqerr
    );

    modport slave (
        input  din, irq_n, nmi_n, irqdis, icyc, rcyc, scyc, sinst,
        output inst, cycle, clr, nmi, irq, seqerr
    );
endinterface

// File: rtl/inst_sequencer.sv
// Instruction register, machine-cycle counter and pending-interrupt flags for
// the 6502 decoder; injects the 00 opcode at instruction boundaries.
module inst_sequencer (
    input  logic                  clk,
    input  logic                  clr_n,
    inst_sequencer_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_INJ = 2'd1,
        ST_INT = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_inst;
    logic [2:0] r_cycle;
    logic       r_seqerr;
    logic       r_rst_pend;
    logic       r_nmi_pend;
    logic       r_irq_s1;
    logic       r_irq_s2;
    logic       r_nmi_s1;
    logic       r_nmi_s2;
    logic       r_nmi_s3;

    logic       w_irq;
    logic       w_nmi_edge;
    logic       w_nmi_clr;
    logic       w_take_int;

    assign w_irq      = ~r_irq_s2 & ~bus.irqdis;
    // r_nmi_s3 is the previous synchronised level, so the edge lands on the 3rd edge
    assign w_nmi_edge = r_nmi_s3 & ~r_nmi_s2;
    assign w_nmi_clr  = bus.sinst & ~r_rst_pend;
    assign w_take_int = r_rst_pend | r_nmi_pend | w_irq;

    // Pin synchronisers and NMI edge-detect history
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_irq_s1 <= 1'b1;
            r_irq_s2 <= 1'b1;
            r_nmi_s1 <= 1'b1;
            r_nmi_s2 <= 1'b1;
            r_nmi_s3 <= 1'b1;
        end else begin
            r_irq_s1 <= bus.irq_n;
            r_irq_s2 <= r_irq_s1;
            r_nmi_s1 <= bus.nmi_n;
            r_nmi_s2 <= r_nmi_s1;
            r_nmi_s3 <= r_nmi_s2;
        end
    end

    // Pending latches: sinst services reset first, then NMI; a fresh NMI edge wins
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rst_pend <= 1'b1;
            r_nmi_pend <= 1'b0;
        end else begin
            r_rst_pend <= r_rst_pend & ~bus.sinst;
            r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_nmi_clr);
        end
    end

    // Sequencer FSM: state, instruction register, cycle counter, overflow error
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= ST_INT;
            r_inst   <= 8'h00;
            r_cycle  <= 3'd0;
            r_seqerr <= 1'b0;
        end else begin
            case (r_state)
                ST_INJ: begin
                    if (!bus.scyc) begin
                        r_state <= ST_INT;
                        r_inst  <= 8'h00;
                        r_cycle <= 3'd0;
                    end else begin
                        r_state <= ST_INJ;
                    end
                end
                ST_RUN, ST_INT: begin
                    if (bus.rcyc) begin
                        r_cycle <= 3'd0;
                        r_state <= w_take_int ? ST_INJ : ST_RUN;
                    end else if (bus.scyc) begin
                        r_cycle <= r_cycle;
                    end else if (bus.icyc) begin
                        // Opcode capture happens only on the cycle-0 edge of a normal instruction
                        if ((r_state == ST_RUN) && (r_cycle == 3'd0)) begin
                            r_inst <= bus.din;
                        end
                        if (r_cycle == 3'd7) begin
                            r_seqerr <= 1'b1;
                        end
                        r_cycle <= r_cycle + 3'd1;
                    end else begin
                        r_cycle <= r_cycle;
                    end
                end
                default: begin
                    r_state <= ST_INT;
                    r_inst  <= 8'h00;
                    r_cycle <= 3'd0;
                end
            endcase
        end
    end

    assign bus.inst   = r_inst;
    assign bus.cycle  = r_cycle;
    assign bus.clr    = r_rst_pend;
    assign bus.nmi    = r_nmi_pend;
    assign bus.irq    = w_irq;
    assign bus.seqerr = r_seqerr;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed scenarios followed by random
// strobes/pins, all compared against a behavioural reference model.
module tb_inst_sequencer;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    inst_sequencer_if bus();
    inst_sequencer u_dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    int n_total = 0;
    int n_bad   = 0;
    int n_edge  = 0;

    // reference model
    logic [7:0] m_inst;
    int         m_cycle;
    bit         m_rst, m_nmi, m_err;
    bit         m_injecting;   // waiting one cycle-0 period before the 00 opcode
    bit         m_in_service;  // inside an interrupt sequence: no opcode fetch
    bit         q_irq[$];      // pin samples, newest at index 0
    bit         q_nmi[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, n_edge, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_inst = 8'h00; m_cycle = 0; m_rst = 1'b1; m_nmi = 1'b0; m_err = 1'b0;
        m_injecting = 1'b0; m_in_service = 1'b1;
        q_irq = '{1'b1, 1'b1, 1'b1};
        q_nmi = '{1'b1, 1'b1, 1'b1};
    endfunction

    function automatic bit model_irq();
        return !q_irq[1] && !bus.irqdis;
    endfunction

    function automatic void model_edge();
        bit take, nmi_edge, clear_nmi;
        take      = m_rst || m_nmi || model_irq();
        nmi_edge  = q_nmi[2] && !q_nmi[1];
        clear_nmi = bus.sinst && !m_rst;
        if (bus.sinst) m_rst = 1'b0;
        m_nmi = nmi_edge || (m_nmi && !clear_nmi);
        if (m_injecting) begin
            if (!bus.scyc) begin
                m_injecting = 1'b0; m_in_service = 1'b1; m_inst = 8'h00; m_cycle = 0;
            end
        end else if (bus.rcyc) begin
            m_cycle = 0;
            m_injecting = take;
            m_in_service = 1'b0;
        end else if (!bus.scyc && bus.icyc) begin
            if (!m_in_service && m_cycle == 0) m_inst = bus.din;
            if (m_cycle == 7) m_err = 1'b1;
            m_cycle = (m_cycle + 1) % 8;
        end
        q_irq.push_front(bus.irq_n); void'(q_irq.pop_back());
        q_nmi.push_front(bus.nmi_n); void'(q_nmi.pop_back());
    endfunction

    task automatic check_all();
        check("inst",   bus.inst, m_inst);
        check("cycle",  {5'd0, bus.cycle}, 8'(m_cycle));
        check("clr",    {7'd0, bus.clr}, {7'd0, m_rst});
        check("nmi",    {7'd0, bus.nmi}, {7'd0, m_nmi});
        check("irq",    {7'd0, bus.irq}, {7'd0, model_irq()});
        check("seqerr", {7'd0, bus.seqerr}, {7'd0, m_err});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        n_edge++;
        #1;
        check_all();
    endtask

    task automatic drive(input bit ic, input bit rc, input bit sc, input bit si);
        bus.icyc = ic; bus.rcyc = rc; bus.scyc = sc; bus.sinst = si;
    endtask

    // called at posedge+1; asserts reset asynchronously and releases it before the next edge
    task automatic do_reset();
        clr_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_inst", bus.inst, 8'h00);
        check("rst_clr", {7'd0, bus.clr}, 8'h01);
        #1;
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n = 1'b0;
        bus.din = 8'h00; bus.irq_n = 1'b1; bus.nmi_n = 1'b1; bus.irqdis = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // reset exit: sinst+icyc, then icyc
        drive(1'b1, 1'b0, 1'b0, 1'b1); step();
        check("rst_exit_clr", {7'd0, bus.clr}, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0); step();
        check("rst_cycle2", {5'd0, bus.cycle}, 8'h02);

        // opcode fetch
        bus.din = 8'h69;
        drive(1'b0, 1'b1, 1'b0, 1'b0); step();
        check("fetch_old_inst", bus.inst, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0); step();
        check("fetch_inst", bus.inst, 8'h69);
        check("fetch_cycle", {5'd0, bus.cycle}, 8'h01);

        // IRQ masked then unmasked
        bus.irqdis = 1'b1; bus.irq_n = 1'b0; bus.din = 8'hA9;
        drive(1'b0, 1'b0, 1'b0, 1'b0); repeat (3) step();
        drive(1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0); step();
        check("masked_fetch", bus.inst, 8'hA9);
        bus.irqdis = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0); step();
        check("inj_inst", bus.inst, 8'h00);
        check("inj_cycle", {5'd0, bus.cycle}, 8'h00);
        check("inj_irq", {7'd0, bus.irq}, 8'h01);
        bus.irq_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0); repeat (3) step();
        drive(1'b0, 1'b1, 1'b0, 1'b0); step();

        // NMI latch and edge/clear collision
        bus.nmi_n = 1'b0; drive(1'b0, 1'b0, 1'b0, 1'b0); step();
        bus.nmi_n = 1'b1; step();
        check("nmi_early", {7'd0, bus.nmi}, 8'h00);
        step();
        check("nmi_set", {7'd0, bus.nmi}, 8'h01);
        bus.nmi_n = 1'b0; step();
        bus.nmi_n = 1'b1; step();
        drive(1'b0, 1'b0, 1'b0, 1'b1); step();
        check("nmi_edge_wins", {7'd0, bus.nmi}, 8'h01);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // priority clear: reset pending beats NMI
        do_reset();
        bus.nmi_n = 1'b0; step();
        bus.nmi_n = 1'b1; repeat (2) step();
        drive(1'b0, 1'b0, 1'b0, 1'b1); step();
        check("prio_clr", {7'd0, bus.clr}, 8'h00);
        check("prio_nmi_kept", {7'd0, bus.nmi}, 8'h01);
        step();
        check("prio_nmi_clr", {7'd0, bus.nmi}, 8'h00);

        // overflow, restart and stall
        drive(1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0); repeat (8) step();
        check("wrap_cycle", {5'd0, bus.cycle}, 8'h00);
        check("wrap_seqerr", {7'd0, bus.seqerr}, 8'h01);
        repeat (3) step();
        drive(1'b1, 1'b1, 1'b0, 1'b0); step();
        check("rcyc_wins", {5'd0, bus.cycle}, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0); repeat (2) step();
        drive(1'b1, 1'b0, 1'b1, 1'b0); step();
        check("stall_hold", {5'd0, bus.cycle}, 8'h02);
        check("seqerr_sticky", {7'd0, bus.seqerr}, 8'h01);
        do_reset();
        check("seqerr_clr", {7'd0, bus.seqerr}, 8'h00);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.din  = 8'($urandom);
            drive(($urandom_range(3, 0) != 0), ($urandom_range(5, 0) == 0),
                  ($urandom_range(7, 0) == 0), ($urandom_range(9, 0) == 0));
            if ($urandom_range(19, 0) == 0) bus.irq_n  = ~bus.irq_n;
            if ($urandom_range(9, 0)  == 0) bus.nmi_n  = ~bus.nmi_n;
            if ($urandom_range(14, 0) == 0) bus.irqdis = ~bus.irqdis;
            if ($urandom_range(399, 0) == 0) do_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
